l1_l2_line_xfer_ctrl: RTL and testbench

- Synthesizable L1-side controller that moves one full cache line between L1 and L2 as a burst of data beats.
- Single-shot L1 request interface in; strobe/ack beat bus out.
- Generalises the single-word we/stb exchange to parametrised address width, data width and burst length.
- Adds a per-beat timeout with error reporting.
- Sits between the L1 miss/writeback logic and the L2 port.

---
 rtl/l1_l2_line_xfer_ctrl.sv | 156 +++++++++++++++
 tb/tb_l1_l2_line_xfer_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/l1_l2_line_xfer_ctrl.sv
// L1-side cache line mover: one L1 request becomes a BEATS-long strobe/ack burst to L2.
// Optional build macro L1L2_ALIGN_CHECK_EN rejects requests whose line-offset bits are nonzero.
module l1_l2_line_xfer_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W*BEATS-1:0]  req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W*BEATS-1:0]  rsp_rdata,
  output logic                     rsp_err,
  output logic                     bus_stb,
  output logic                     bus_we,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_wdata,
  input  logic                     bus_ack,
  input  logic [DATA_W-1:0]        bus_rdata
);

  // state | meaning
  // IDLE  | waiting for an L1 request, req_ready high
  // BEAT  | strobing the current beat, waiting for bus_ack or timeout
  // RESP  | one-cycle completion pulse, rsp_err qualifies it

  localparam int BYTES  = DATA_W / 8;
  localparam int LINE_W = DATA_W * BEATS;
  localparam int OFF    = $clog2(BEATS * BYTES);
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);
  localparam logic [BW-1:0]     LAST     = BW'(BEATS - 1);
  localparam logic [TW-1:0]     TMAX     = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic [BW-1:0]       beat_q, beat_d, beat_inc;
  logic [TW-1:0]       timer_q, timer_d, timer_inc;
  logic                err_q, err_d;
  logic                bus_stb_q, bus_stb_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;

  assign req_ready = (state_q == IDLE) & ~rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = (state_q == RESP) & err_q;
  assign rsp_rdata = rdata_q;
  assign bus_stb   = bus_stb_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    beat_d    = beat_q;
    timer_d   = timer_q;
    err_d     = err_q;
    beat_inc  = (beat_q == LAST) ? '0 : beat_q + BW'(1);
    timer_inc = timer_q + TW'(1);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          base_d  = req_addr & ~OFF_MASK;
          wdata_d = req_wdata;
          rdata_d = '0;
          beat_d  = '0;
          timer_d = '0;
          err_d   = 1'b0;
          state_d = BEAT;
`ifdef L1L2_ALIGN_CHECK_EN
          if (|(req_addr & OFF_MASK)) begin
            state_d = RESP;
            err_d   = 1'b1;
          end
`endif
        end
      end
      BEAT: begin
        if (bus_ack) begin
          if (!we_q) rdata_d[beat_q*DATA_W +: DATA_W] = bus_rdata;
          timer_d = '0;
          beat_d  = beat_inc;
          if (beat_q == LAST) state_d = RESP;
        end else begin
          timer_d = timer_inc;
          if ((TIMEOUT != 0) && (timer_inc == TMAX)) begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered copies of what the next cycle presents.
    bus_stb_d   = (state_d == BEAT);
    bus_we_d    = (state_d == BEAT) & we_d;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if (state_d == BEAT) begin
      bus_addr_d  = base_d + ADDR_W'(beat_d) * ADDR_W'(BYTES);
      bus_wdata_d = wdata_d[beat_d*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      beat_q      <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      bus_stb_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      beat_q      <= beat_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      bus_stb_q   <= bus_stb_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_l1_l2_line_xfer_ctrl.sv
// Directed bench for l1_l2_line_xfer_ctrl (ADDR_W=32, DATA_W=64, BEATS=4, TIMEOUT=4).
// Covers read, stalled write, timeout, mid-burst reset, back-to-back and misaligned requests.
module tb_l1_l2_line_xfer_ctrl;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [31:0]  req_addr;
  logic [255:0] req_wdata;
  logic         rsp_valid;
  logic [255:0] rsp_rdata;
  logic         rsp_err;
  logic         bus_stb;
  logic         bus_we;
  logic [31:0]  bus_addr;
  logic [63:0]  bus_wdata;
  logic         bus_ack;
  logic [63:0]  bus_rdata;

  int checks = 0;
  int errors = 0;

  l1_l2_line_xfer_ctrl #(
    .ADDR_W(32), .DATA_W(64), .BEATS(4), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input logic [63:0] pat);
    logic [255:0] l;
    for (int k = 0; k < 4; k++) l[k*64 +: 64] = 64'(pat * 64'(k + 1));
    return l;
  endfunction

  // Issue a read, ack every cycle with pat*(k+1), check addresses and the response.
  task automatic run_read(input logic [31:0] addr, input logic [31:0] base, input logic [63:0] pat);
    @(negedge clk);
    chk("rd_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("rd_stb", bus_stb, 1'b1);
      chk("rd_we", bus_we, 1'b0);
      chk("rd_addr", bus_addr, base + 32'(8 * k));
      chk("rd_valid_low", rsp_valid, 1'b0);
      bus_ack = 1'b1; bus_rdata = 64'(pat * 64'(k + 1));
    end
    @(negedge clk);
    bus_ack = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_err", rsp_err, 1'b0);
    chk("rd_rsp_rdata", rsp_rdata, line_of(pat));
    chk("rd_stb_off", bus_stb, 1'b0);
    @(negedge clk);
    chk("rd_rsp_once", rsp_valid, 1'b0);
  endtask

  logic [255:0] wline;
  logic [255:0] exp_line;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_stb", bus_stb, 1'b0);
    chk("rst_we", bus_we, 1'b0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 64'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rdata", rsp_rdata, 256'h0);
    rst = 1'b0;
    #1;
    chk("idle_ready", req_ready, 1'b1);

    // Read with acks every cycle: 0x11.., 0x22.., 0x33.., 0x44..
    run_read(32'h0000_1000, 32'h0000_1000, 64'h1111_1111_1111_1111);

    // Write, each beat acked on its fourth cycle
    wline = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_2000; req_wdata = wline;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        req_valid = 1'b0;
        chk("wr_stb", bus_stb, 1'b1);
        chk("wr_we", bus_we, 1'b1);
        chk("wr_addr", bus_addr, 32'h2000 + 32'(8 * k));
        chk("wr_wdata", bus_wdata, wline[k*64 +: 64]);
        chk("wr_valid_low", rsp_valid, 1'b0);
        bus_ack = (s == 3);
      end
    end
    @(negedge clk);
    bus_ack = 1'b0; req_we = 1'b0;
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_rsp_err", rsp_err, 1'b0);
    chk("wr_rdata_zero", rsp_rdata, 256'h0);
    chk("wr_stb_off", bus_stb, 1'b0);
    @(negedge clk);
    chk("wr_rsp_once", rsp_valid, 1'b0);

    // Timeout: beat 0 acked, then four idle cycles abort the burst
    req_valid = 1'b1; req_addr = 32'h0000_3000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("to_addr0", bus_addr, 32'h3000);
    bus_ack = 1'b1; bus_rdata = 64'h5555_5555_5555_5555;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      chk("to_stb_wait", bus_stb, 1'b1);
      chk("to_addr1", bus_addr, 32'h3008);
      chk("to_valid_low", rsp_valid, 1'b0);
    end
    @(negedge clk);
    chk("to_stb_off", bus_stb, 1'b0);
    chk("to_rsp_valid", rsp_valid, 1'b1);
    chk("to_rsp_err", rsp_err, 1'b1);
    chk("to_rdata", rsp_rdata, {192'h0, 64'h5555_5555_5555_5555});
    @(negedge clk);
    chk("to_rsp_once", rsp_valid, 1'b0);
    chk("to_err_clear", rsp_err, 1'b0);

    // Reset during beat 2
    req_valid = 1'b1; req_addr = 32'h0000_4000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("rb_addr", bus_addr, 32'h4000 + 32'(8 * k));
      bus_ack = (k < 2); bus_rdata = 64'h0F0F_0F0F_0F0F_0F0F;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rb_stb", bus_stb, 1'b0);
    chk("rb_we", bus_we, 1'b0);
    chk("rb_addr_zero", bus_addr, 32'h0);
    chk("rb_wdata_zero", bus_wdata, 64'h0);
    chk("rb_rdata_zero", rsp_rdata, 256'h0);
    chk("rb_rsp_valid", rsp_valid, 1'b0);
    chk("rb_rsp_err", rsp_err, 1'b0);
    @(negedge clk);
    chk("rb_no_rsp", rsp_valid, 1'b0);
    run_read(32'h0000_5000, 32'h0000_5000, 64'h0101_0101_0101_0101);

    // Spurious ack in IDLE must change nothing
    exp_line = line_of(64'h0101_0101_0101_0101);
    bus_ack = 1'b1; bus_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("sp_stb", bus_stb, 1'b0);
    chk("sp_rsp_valid", rsp_valid, 1'b0);
    chk("sp_rdata_hold", rsp_rdata, exp_line);
    chk("sp_ready", req_ready, 1'b1);

    // Back-to-back with req_valid held high
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_6000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bb1_ready_low", req_ready, 1'b0);
      chk("bb1_addr", bus_addr, 32'h6000 + 32'(8 * k));
      bus_ack = 1'b1; bus_rdata = 64'(64'h0202_0202_0202_0202 * 64'(k + 1));
      req_addr = 32'h0000_7000;
    end
    @(negedge clk);
    bus_ack = 1'b0;
    chk("bb1_ready_resp", req_ready, 1'b0);
    chk("bb1_rsp_valid", rsp_valid, 1'b1);
    chk("bb1_rdata", rsp_rdata, line_of(64'h0202_0202_0202_0202));
    @(negedge clk);
    chk("bb_ready_spacing", req_ready, 1'b1);
    chk("bb_idle_valid", rsp_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("bb2_stb", bus_stb, 1'b1);
      chk("bb2_ready_low", req_ready, 1'b0);
      chk("bb2_addr", bus_addr, 32'h7000 + 32'(8 * k));
      bus_ack = 1'b1; bus_rdata = 64'(64'h0303_0303_0303_0303 * 64'(k + 1));
    end
    @(negedge clk);
    bus_ack = 1'b0;
    chk("bb2_rsp_valid", rsp_valid, 1'b1);
    chk("bb2_rdata", rsp_rdata, line_of(64'h0303_0303_0303_0303));
    @(negedge clk);

    // Misaligned request
`ifdef L1L2_ALIGN_CHECK_EN
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_1004;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mis_stb", bus_stb, 1'b0);
    chk("mis_rsp_valid", rsp_valid, 1'b1);
    chk("mis_rsp_err", rsp_err, 1'b1);
    @(negedge clk);
    chk("mis_stb_after", bus_stb, 1'b0);
    chk("mis_rsp_once", rsp_valid, 1'b0);
`else
    run_read(32'h0000_1004, 32'h0000_1000, 64'h0707_0707_0707_0707);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
